// File: rtl/prbs13_pkg.sv
// rtl/prbs13_pkg.sv - shared constants and state type for the PRBS13 checker
package prbs13_pkg;

    localparam int PRBS_W = 13;

    // Feedback taps in history order: h[0] is the newest bit.
    localparam int TAP_A = 12;
    localparam int TAP_B = 3;
    localparam int TAP_C = 2;
    localparam int TAP_D = 0;

    localparam logic [PRBS_W-1:0] PRBS_SEED = 13'b1000000001101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/prbs13_checker.sv
// rtl/prbs13_checker.sv - PRBS13 serial checker: hunt, self-resync check, locked error counting
module prbs13_checker
    import prbs13_pkg::*;
#(
    parameter int LOCK_COUNT = 32,
    parameter int ERR_WINDOW = 64,
    parameter int ERR_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_tick,
    output logic        sync_loss,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    localparam int HW = $clog2(PRBS_W + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(ERR_WINDOW + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    state_e              state_q, state_d;
    logic [PRBS_W-1:0]   hist_q, hist_d;
    logic [HW-1:0]       hunt_cnt_q, hunt_cnt_d;
    logic [MW-1:0]       match_q, match_d;
    logic [WW-1:0]       win_bits_q, win_bits_d;
    logic [EW-1:0]       win_errs_q, win_errs_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [31:0]         bit_cnt_q, bit_cnt_d;
    logic                err_tick_q, err_tick_d;
    logic                sync_loss_q, sync_loss_d;

    logic predict;
    logic mismatch;
    logic limit_hit;

    assign predict   = hist_q[TAP_A] ^ hist_q[TAP_B] ^ hist_q[TAP_C] ^ hist_q[TAP_D];
    assign mismatch  = bit_in ^ predict;
    assign limit_hit = mismatch && (win_errs_q == EW'(ERR_LIMIT - 1));

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        hunt_cnt_d  = hunt_cnt_q;
        match_d     = match_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_tick_d  = 1'b0;
        sync_loss_d = 1'b0;

        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    hist_d = {hist_q[PRBS_W-2:0], bit_in};
                    if (hunt_cnt_q == HW'(PRBS_W - 1)) begin
                        state_d    = CHECK;
                        hunt_cnt_d = '0;
                        match_d    = '0;
                    end else begin
                        hunt_cnt_d = hunt_cnt_q + 1'b1;
                    end
                end

                CHECK: begin
                    hist_d = {hist_q[PRBS_W-2:0], bit_in};
                    // An all-zero history predicts zero forever, so it must never count as a match.
                    if (!mismatch && (hist_q != '0)) begin
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d    = LOCKED;
                            match_d    = '0;
                            win_bits_d = '0;
                            win_errs_d = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel on the prediction so a single bad bit costs exactly one error.
                    hist_d    = {hist_q[PRBS_W-2:0], predict};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (mismatch) begin
                        err_tick_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    if (limit_hit) begin
                        state_d     = HUNT;
                        sync_loss_d = 1'b1;
                        hunt_cnt_d  = '0;
                        win_bits_d  = '0;
                        win_errs_d  = '0;
                    end else if (win_bits_q == WW'(ERR_WINDOW - 1)) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = win_bits_q + 1'b1;
                        win_errs_d = win_errs_q + EW'(mismatch);
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        if (clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            hist_q      <= '0;
            hunt_cnt_q  <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            err_tick_q  <= 1'b0;
            sync_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            hunt_cnt_q  <= hunt_cnt_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_tick_q  <= err_tick_d;
            sync_loss_q <= sync_loss_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_tick  = err_tick_q;
    assign sync_loss = sync_loss_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs13_checker.sv
// tb/tb_prbs13_checker.sv - scoreboard bench for prbs13_checker against a queue-based reference model
module tb_prbs13_checker;

    localparam int LOCK = 32;
    localparam int WIN  = 64;
    localparam int LIM  = 8;
    localparam int NSTR = 8000;

    logic        clk;
    logic        reset_n;
    logic        bit_in;
    logic        bit_valid;
    logic        clear;
    logic        locked;
    logic        err_tick;
    logic        sync_loss;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    prbs13_checker #(.LOCK_COUNT(LOCK), .ERR_WINDOW(WIN), .ERR_LIMIT(LIM)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear     (clear),
        .locked    (locked),
        .err_tick  (err_tick),
        .sync_loss (sync_loss),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        lk;
        logic        tk;
        logic        sl;
        logic [15:0] ec;
        logic [31:0] bc;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ticks = 0;
    int   losses = 0;
    int   lock_hi = 0;
    int   cyc = 0;

    // Reference stream: s(n+13) = s(n+12) ^ s(n+10) ^ s(n+9) ^ s(n), seeded MSB first.
    bit   stream[NSTR];
    int   gi = 0;

    // Reference model: 0 = hunting, 1 = checking, 2 = locked.
    int          mode;
    bit          hist[$];
    int          hunt_n, run, wbits, werrs;
    int          errc;
    logic [31:0] bitc;
    bit          m_tick, m_loss;

    function automatic void model_reset();
        mode = 0; hunt_n = 0; run = 0; wbits = 0; werrs = 0;
        errc = 0; bitc = '0; m_tick = 0; m_loss = 0;
        hist.delete();
        for (int k = 0; k < 13; k++) hist.push_back(1'b0);
    endfunction

    function automatic void model_step(bit b, bit v, bit clr);
        bit p, nz;
        m_tick = 0;
        m_loss = 0;
        if (v) begin
            p  = hist[0] ^ hist[2] ^ hist[3] ^ hist[12];
            nz = 0;
            foreach (hist[k]) nz |= hist[k];
            if (mode == 0) begin
                hist.push_front(b); void'(hist.pop_back());
                hunt_n++;
                if (hunt_n == 13) begin mode = 1; run = 0; hunt_n = 0; end
            end else if (mode == 1) begin
                hist.push_front(b); void'(hist.pop_back());
                if (b == p && nz) run++; else run = 0;
                if (run == LOCK) begin mode = 2; run = 0; wbits = 0; werrs = 0; end
            end else begin
                hist.push_front(p); void'(hist.pop_back());
                bitc++;
                wbits++;
                if (b != p) begin
                    m_tick = 1;
                    if (errc < 65535) errc++;
                    werrs++;
                end
                if (werrs == LIM) begin
                    mode = 0; hunt_n = 0; wbits = 0; werrs = 0; m_loss = 1;
                end else if (wbits == WIN) begin
                    wbits = 0; werrs = 0;
                end
            end
        end
        if (clr) begin errc = 0; bitc = '0; end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drive(input logic b, input logic v, input logic clr, input logic rst);
        obs_t e;
        @(negedge clk);
        bit_in = b; bit_valid = v; clear = clr; reset_n = rst;
        if (!rst) model_reset(); else model_step(b, v, clr);
        e = '{lk: (mode == 2), tk: m_tick, sl: m_loss, ec: 16'(errc), bc: bitc};
        exp_q.push_back(e);
        if (!rst) begin
            #1;
            check("rst_outputs", {locked, err_tick, sync_loss, err_count, bit_count}, 32'd0);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    // Feed a clean stream and demand lock exactly on the 45th valid bit.
    task automatic lock_run(input int pct, input string tag);
        int n, guard;
        logic v, b;
        n = 0; guard = 0;
        while (n < 45 && guard < 2000) begin
            v = (($urandom % 100) < pct);
            if (v) begin b = stream[gi]; gi++; end else b = 1'($urandom % 2);
            drive(b, v, 1'b0, 1'b1);
            guard++;
            if (v) begin
                n++;
                if (n == 44 || n == 45) begin
                    wait_edge();
                    check({tag, (n == 45) ? "_lock45" : "_nolock44"}, {31'd0, locked}, (n == 45) ? 32'd1 : 32'd0);
                end
            end
        end
        if (n < 45) check({tag, "_timeout"}, n, 45);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {locked, err_tick, sync_loss, err_count, bit_count};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL scoreboard cyc=%0d got lk=%b tk=%b sl=%b ec=%0d bc=%0d want lk=%b tk=%b sl=%b ec=%0d bc=%0d",
                             cyc, a.lk, a.tk, a.sl, a.ec, a.bc, e.lk, e.tk, e.sl, e.ec, e.bc);
                end
                if (err_tick)  ticks++;
                if (sync_loss) losses++;
                if (locked)    lock_hi++;
            end
        end
    end

    initial begin : stim
        int t0, l0, h0, k, guard;
        logic v, b;
        logic [12:0] seed;

        reset_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
        model_reset();
        seed = prbs13_pkg::PRBS_SEED;
        for (int i = 0; i < 13; i++) stream[i] = seed[12-i];
        for (int n = 0; n + 13 < NSTR; n++)
            stream[n+13] = stream[n+12] ^ stream[n+10] ^ stream[n+9] ^ stream[n];

        // Reset held with bit_valid toggling.
        for (int i = 0; i < 8; i++) drive(1'($urandom % 2), 1'(i % 2), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Clean stream from the seed, valid every cycle.
        lock_run(100, "seed");
        for (int i = 0; i < 100; i++) begin drive(stream[gi], 1'b1, 1'b0, 1'b1); gi++; end
        wait_edge();
        check("clean_err_count", {16'd0, err_count}, 32'd0);
        check("clean_bit_count", bit_count, 32'd100);

        // Single inverted bit.
        t0 = ticks;
        drive(~stream[gi], 1'b1, 1'b0, 1'b1); gi++;
        for (int i = 0; i < 20; i++) begin drive(stream[gi], 1'b1, 1'b0, 1'b1); gi++; end
        wait_edge();
        check("one_err_ticks", ticks - t0, 1);
        check("one_err_count", {16'd0, err_count}, 32'd1);
        check("one_err_locked", {31'd0, locked}, 32'd1);

        // Error coinciding with clear: clear wins.
        drive(~stream[gi], 1'b1, 1'b1, 1'b1); gi++;
        wait_edge();
        check("clear_err_count", {16'd0, err_count}, 32'd0);
        check("clear_bit_count", bit_count, 32'd0);
        for (int i = 0; i < 10; i++) begin drive(stream[gi], 1'b1, 1'b0, 1'b1); gi++; end

        // Burst of errors until the window limit forces resync.
        l0 = losses; k = 0;
        while (mode == 2 && k < 15) begin
            drive(~stream[gi], 1'b1, 1'b0, 1'b1); gi++; k++;
        end
        wait_edge();
        check("burst_unlocked", {31'd0, locked}, 32'd0);
        check("burst_sync_loss", losses - l0, 1);
        lock_run(100, "relock");

        // Random valid, sparse bit errors and clears.
        for (int i = 0; i < 400; i++) begin
            v = (($urandom % 2) == 1);
            b = v ? stream[gi] : 1'($urandom % 2);
            if (v) gi++;
            if (v && ($urandom % 30) == 0) b = ~b;
            drive(b, v, 1'(($urandom % 40) == 0), 1'b1);
        end

        // Lock with 50% valid, then pulse reset while locked.
        guard = 0;
        while (mode != 2 && guard < 2000) begin
            v = (($urandom % 2) == 1);
            if (v) begin b = stream[gi]; gi++; end else b = 1'($urandom % 2);
            drive(b, v, 1'b0, 1'b1);
            guard++;
        end
        wait_edge();
        check("pre_reset_locked", {31'd0, locked}, 32'd1);
        drive(stream[gi], 1'b1, 1'b0, 1'b0); gi++;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        lock_run(50, "half_valid");

        // Constant-zero then constant-one streams must never lock.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        h0 = lock_hi;
        for (int i = 0; i < 1000; i++) drive(1'b0, 1'b1, 1'b0, 1'b1);
        wait_edge();
        check("zeros_no_lock", lock_hi - h0, 0);
        h0 = lock_hi;
        for (int i = 0; i < 200; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        wait_edge();
        check("ones_no_lock", lock_hi - h0, 0);

        @(posedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs13_checker.md
PRBS13_CHECKER -- requirements
Module: prbs13_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 32: consecutive correct predictions needed to declare lock.
REQ-002 Parameter ERR_WINDOW, default 64: length of the loss-of-sync window, in locked valid bits.
REQ-003 Parameter ERR_LIMIT, default 8: number of errors within one window that forces resync.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 bit_in  input  1  received serial bit from a 13-bit PRBS generator, MSB-of-register-first.
REQ-007 bit_valid  input  1  bit_in is sampled only on cycles where this is 1.
REQ-008 clear  input  1  synchronous clear of err_count and bit_count; does not affect lock.
REQ-009 locked  output  1  high while the checker is in the LOCKED state.
REQ-010 err_tick  output  1  one-cycle pulse for each mismatch detected while LOCKED.
REQ-011 sync_loss  output  1  one-cycle pulse when the state goes from LOCKED to HUNT.
REQ-012 err_count  output  16  mismatches counted while LOCKED; saturates at 16'hFFFF.
REQ-013 bit_count  output  32  valid bits checked while LOCKED; wraps modulo 2^32.

Function
REQ-014 The checker keeps a 13-bit history h, where h[0] is the newest accepted bit and h[k] is the bit accepted k bits earlier.
REQ-015 Predicted next bit p = h[0]^h[2]^h[3]^h[12], matching the recurrence s(n+13)=s(n+12)^s(n+10)^s(n+9)^s(n).
REQ-016 The states are HUNT, CHECK and LOCKED; on every cycle with bit_valid=0, all state, history and counters hold.
REQ-017 HUNT: shift bit_in into h on each valid bit; after the 13th valid bit, go to CHECK with match counter 0.
REQ-018 CHECK: shift bit_in into h; bit_in==p and h!=0 increments the match counter; a mismatch resets it to 0 and the state stays CHECK (self-resync).
REQ-019 CHECK with h all-zero: the match counter is held at 0, so an all-zero stream never locks.
REQ-020 CHECK: when the match counter reaches LOCK_COUNT, go to LOCKED; locked is 1 from the next cycle.
REQ-021 LOCKED: shift p (not bit_in) into h, so that one corrupted bit causes exactly one error.
REQ-022 LOCKED mismatch (bit_in!=p): err_tick=1 the following cycle; err_count+1 unless already at 16'hFFFF; the window error counter +1.
REQ-023 LOCKED: each valid bit increments bit_count and the window bit counter.
REQ-024 When the window bit counter reaches ERR_WINDOW, both window counters reset to 0.
REQ-025 When the window error count reaches ERR_LIMIT: go to HUNT, sync_loss=1 for one cycle, locked=0 on the next cycle, and reset the HUNT bit counter and window counters.
REQ-026 If clear coincides with a counted error or bit, clear wins: the counters become 0, not 1.
REQ-027 err_tick and sync_loss are registered and are never high for two consecutive cycles from a single event.

Reset
REQ-028 reset_n=0 immediately forces: state=HUNT, h=0, all internal counters=0, locked=0, err_tick=0, sync_loss=0, err_count=0, bit_count=0.
REQ-029 Reset asserted mid-lock or mid-hunt discards all progress; after release, locking restarts from the first valid bit.

Structure
REQ-030 Shared package prbs13_pkg holds the tap positions {12,3,2,0}, the 13-bit width, the generator seed 13'b1000000001101, and the state enum {HUNT, CHECK, LOCKED}.
REQ-031 The design is a single flat module; the prediction XOR is inline logic, with no sub-module.

Verification
REQ-032 Reset -> all outputs 0 and state HUNT; reset_n held low with bit_valid toggling -> outputs stay 0.
REQ-033 Generator stream from seed 13'h100D (first bits 1000000001101), valid every cycle -> locked rises the cycle after the 45th valid bit; err_count=0; bit_count counts subsequent bits.
REQ-034 Locked, invert one bit -> exactly one err_tick pulse, err_count=1, locked stays 1.
REQ-035 Locked, invert 8 bits within 64 valid bits -> sync_loss pulse, locked=0; clean stream then relocks after 45 further valid bits.
REQ-036 Constant-0 input for 1000 bits -> locked never rises; constant-1 input -> no lock.
REQ-037 Clean stream with bit_valid=0 on random 50% of cycles -> lock after 45 valid bits; reset_n pulsed while locked -> immediate 0 outputs and relock after 45 valid bits.
